// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with a guard band between
// slots, shadow/active digit registers committed at frame boundaries, and leading-zero blanking.
module seven_seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic        lz_blank,
  output logic [3:0]  hex_out,
  output logic [3:0]  an_n,
  output logic        frame_tick
);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_GUARD,
    ST_DRIVE
  } state_t;

  localparam logic [15:0] GUARD_LAST = 16'(GUARD - 1);
  localparam logic [15:0] SLOT_LAST  = 16'(REFRESH_DIV - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [15:0] active, shadow;
  logic        pending;
  logic        boundary;
  logic [3:0]  digit_sel;
  logic        blank;
  logic [3:0]  an_nxt, hex_nxt;

  // One slot counter spans the whole slot: 0..GUARD-1 in GUARD, GUARD..REFRESH_DIV-1 in DRIVE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    boundary  = 1'b0;
    if (!en) begin
      state_nxt = ST_OFF;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_OFF: begin
          state_nxt = ST_GUARD;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
        ST_GUARD: begin
          cnt_nxt = cnt + 16'd1;
          if (cnt == GUARD_LAST) state_nxt = ST_DRIVE;
        end
        ST_DRIVE: begin
          if (cnt == SLOT_LAST) begin
            state_nxt = ST_GUARD;
            cnt_nxt   = '0;
            idx_nxt   = idx + 2'd1;
            boundary  = (idx == 2'd3);
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
        default: begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are computed from the next state so the registered values line up with the state.
  always_comb begin
    digit_sel = active[3:0];
    blank     = 1'b0;
    case (idx_nxt)
      2'd0: digit_sel = active[3:0];
      2'd1: begin
        digit_sel = active[7:4];
        blank     = (active[15:4] == 12'h000);
      end
      2'd2: begin
        digit_sel = active[11:8];
        blank     = (active[15:8] == 8'h00);
      end
      default: begin
        digit_sel = active[15:12];
        blank     = (active[15:12] == 4'h0);
      end
    endcase
    an_nxt  = '1;
    hex_nxt = '1;
    if (state_nxt == ST_DRIVE) begin
      an_nxt  = ~(4'b0001 << idx_nxt);
      hex_nxt = (lz_blank && blank) ? 4'hF : digit_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_OFF;
      cnt        <= '0;
      idx        <= '0;
      an_n       <= '1;
      hex_out    <= '1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      an_n       <= an_nxt;
      hex_out    <= hex_nxt;
      frame_tick <= boundary;
    end
  end

  // Commit happens only on the edge into GUARD, so a lit digit never changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else if (boundary) begin
      if (load)         active <= digits_in;
      else if (pending) active <= shadow;
      if (load) shadow <= digits_in;
      pending <= 1'b0;
    end else if (load) begin
      shadow  <= digits_in;
      pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl (REFRESH_DIV=8, GUARD=2) against a
// phase-arithmetic reference model of the scan timing and digit commit rules.
module tb_seven_seg_scan_ctrl;
  localparam int RD = 8;
  localparam int G  = 2;

  logic        clk = 1'b0;
  logic        rst_n, en, load, lz_blank;
  logic [15:0] digits_in;
  logic [3:0]  hex_out, an_n;
  logic        frame_tick;

  int tests = 0;
  int fails = 0;

  // Reference model: time since scanning started, plus digit registers
  bit          m_run = 1'b0;
  int          m_phase = 0;
  logic [15:0] m_act = '0, m_shd = '0;
  bit          m_pend = 1'b0;
  bit          m_tick = 1'b0;
  bit          m_lz = 1'b0;

  seven_seg_scan_ctrl #(.REFRESH_DIV(RD), .GUARD(G)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
    .lz_blank(lz_blank), .hex_out(hex_out), .an_n(an_n), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_phase = 0; m_act = '0; m_shd = '0; m_pend = 1'b0; m_tick = 1'b0;
  endtask

  task automatic model_edge();
    bit bnd;
    bnd = 1'b0;
    if (!en) begin
      m_run = 1'b0; m_phase = 0;
    end else if (!m_run) begin
      m_run = 1'b1; m_phase = 0;
    end else begin
      m_phase++;
      if (m_phase == 4 * RD) begin
        m_phase = 0;
        bnd = 1'b1;
      end
    end
    if (bnd) begin
      if (load) m_act = digits_in;
      else if (m_pend) m_act = m_shd;
      if (load) m_shd = digits_in;
      m_pend = 1'b0;
    end else if (load) begin
      m_shd = digits_in;
      m_pend = 1'b1;
    end
    m_tick = bnd;
    m_lz = lz_blank;
  endtask

  task automatic check_outputs();
    logic [3:0]  e_an, e_hex;
    logic [15:0] sh;
    int          idx;
    e_an = 4'hF;
    e_hex = 4'hF;
    if (m_run && (m_phase % RD) >= G) begin
      idx = m_phase / RD;
      e_an[idx] = 1'b0;
      sh = m_act >> (4 * idx);
      e_hex = (m_lz && idx > 0 && sh == 16'h0000) ? 4'hF : sh[3:0];
    end
    chk("an_n", {12'h0, an_n}, {12'h0, e_an});
    chk("hex_out", {12'h0, hex_out}, {12'h0, e_hex});
    chk("frame_tick", {15'h0, frame_tick}, {15'h0, m_tick});
    chk("single_anode", {15'h0, ($countones(~an_n) <= 1)}, 16'h0001);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] d);
    load = 1'b1; digits_in = d;
    step();
    load = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    int k;
    k = 0;
    while (!(m_run && m_phase == p) && k < 200) begin
      step();
      k++;
    end
    chk("wait_phase_bound", {15'h0, (k < 200)}, 16'h0001);
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] d;
    for (int i = 0; i < 4; i++)
      d[4*i +: 4] = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
    return d;
  endfunction

  initial begin
    rst_n = 1'b1; en = 1'b0; load = 1'b0; digits_in = '0; lz_blank = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_an_n", {12'h0, an_n}, 16'h000F);
    chk("reset_hex", {12'h0, hex_out}, 16'h000F);
    chk("reset_tick", {15'h0, frame_tick}, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold_an_n", {12'h0, an_n}, 16'h000F);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic scan of 1234, committed at the first frame boundary
    en = 1'b1;
    do_load(16'h1234);
    run(4 * RD * 3);

    // Leading-zero blanking
    lz_blank = 1'b1;
    do_load(16'h0050);
    run(4 * RD * 2 + 5);
    do_load(16'h0000);
    run(4 * RD * 2);
    lz_blank = 1'b0;

    // Last load wins; the first one must never reach the display
    wait_phase(9);
    do_load(16'h1111);
    run(6);
    do_load(16'h2222);
    run(4 * RD * 2);

    // Load landing exactly on the boundary edge
    wait_phase(4 * RD - 1);
    do_load(16'h9876);
    run(4 * RD + 3);

    // Enable dropped during DRIVE of digit 2, then restored
    wait_phase(2 * RD + G + 1);
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(4 * RD * 2);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if (c % 97 == 0) lz_blank = 1'($urandom);
      en = ($urandom % 150) != 0;
      load = ($urandom % 30) == 0;
      digits_in = rand_digits();
      step();
      load = 1'b0;
    end
    en = 1'b1;
    run(4 * RD * 2);

    // Asynchronous reset in the middle of a DRIVE slot
    wait_phase(RD + G + 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_an_n", {12'h0, an_n}, 16'h000F);
    chk("async_reset_hex", {12'h0, hex_out}, 16'h000F);
    chk("async_reset_tick", {15'h0, frame_tick}, 16'h0000);
    model_reset();
    #2 rst_n = 1'b1;
    run(4 * RD * 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clock cycles per digit slot; legal range 2..65535.
REQ-002 Parameter GUARD, default 16: anode-off cycles at the start of each slot; legal range 1..REFRESH_DIV-1.
REQ-003 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-005 Port en, input, 1, scan enable; 0 forces display dark.
REQ-006 Port load, input, 1, single-cycle strobe; captures digits_in.
REQ-007 Port digits_in, input, 16, four 4-bit digit codes; [3:0] = digit 0 (rightmost), [15:12] = digit 3 (leftmost).
REQ-008 Port lz_blank, input, 1, leading-zero blanking enable.
REQ-009 Port hex_out, input-to-decoder code, output, 4, drives the seven-segment hex decoder; 4'hF = blank.
REQ-010 Port an_n, output, 4, active-low digit anode enables; bit i selects digit i.
REQ-011 Port frame_tick, output, 1, one-cycle pulse at each frame boundary.

Function
REQ-012 The block SHALL contain an FSM with states OFF, GUARD, DRIVE.
REQ-013 OFF: an_n=4'b1111, hex_out=4'hF, slot counter=0, digit index=0; on en=1 the next state SHALL be GUARD with digit index 0.
REQ-014 GUARD: an_n=4'b1111, hex_out=4'hF; after exactly GUARD cycles the FSM SHALL enter DRIVE.
REQ-015 DRIVE: an_n SHALL have only bit [index] low; hex_out SHALL be the active digit[index], or 4'hF if blanked per REQ-019.
REQ-016 DRIVE SHALL last exactly REFRESH_DIV-GUARD cycles, then the digit index SHALL increment modulo 4 and the FSM SHALL return to GUARD; total slot = REFRESH_DIV cycles, frame = 4*REFRESH_DIV cycles.
REQ-017 Frame boundary = the DRIVE-to-GUARD transition with index 3 wrapping to 0; frame_tick SHALL be high for exactly the first GUARD cycle of the new frame.
REQ-018 load=1 SHALL capture digits_in into a shadow register and set a pending flag; at the next frame boundary the shadow SHALL copy into the active register and pending SHALL clear; a load coinciding with the boundary edge SHALL be committed at that boundary; a second load before commit SHALL overwrite the shadow (last wins).
REQ-019 With lz_blank=1, digit i (i=3,2,1) SHALL be blanked if digit i and all higher digits of the active register equal 0; digit 0 SHALL never be blanked; lz_blank SHALL be sampled combinationally each DRIVE cycle.
REQ-020 Digit codes 4'hA-4'hF SHALL pass to hex_out unchanged (decoder renders them blank).
REQ-021 en=0 in any state SHALL force OFF at the next rising edge; active/shadow registers and pending flag SHALL be retained.
REQ-022 an_n and hex_out SHALL be registered outputs; no two anodes SHALL ever be low in the same cycle.
REQ-023 Active-register update occurs only during GUARD so a digit never changes while its anode is on.

Reset
REQ-024 rst_n=0 SHALL immediately force: FSM=OFF, an_n=4'b1111, hex_out=4'hF, frame_tick=0, counters=0, active=shadow=16'h0000, pending=0.
REQ-025 Reset mid-slot SHALL abort the slot; after release with en=1, scanning SHALL restart at GUARD, index 0.

Verification (REFRESH_DIV=8, GUARD=2)
REQ-026 Reset, en=1, load digits_in=16'h1234 -> after first boundary, per slot: 2 cycles an_n=1111/hex_out=F, then 6 cycles an_n=1110 hex_out=4, 1101/3, 1011/2, 0111/1; frame_tick every 32 cycles.
REQ-027 lz_blank=1, active=16'h0050 -> digit3 and digit2 hex_out=F with anodes still sequenced, digit1=5, digit0=0; active=16'h0000 -> only digit0 shows 0.
REQ-028 load 16'h1111 mid-frame then load 16'h2222 before boundary -> display shows 2222 from next frame; 1111 never displayed.
REQ-029 en dropped during DRIVE of digit 2 -> next cycle an_n=1111, hex_out=F; en restored -> GUARD, index 0, previous digits shown.
REQ-030 rst_n pulsed low mid-DRIVE (asynchronous, between edges) -> an_n=1111 immediately; after release digits read 0000.
REQ-031 Every cycle of all tests: at most one an_n bit low; hex_out stable whenever any an_n bit is low within a slot.
